// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store issue unit.
// Size encodings plus the alignment rule used by ex_lsu_issue.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    // Doublewords are only legal on a 64-bit bus.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [2:0] lo,
                                            input logic       bus64);
        logic bad;
        case (lsu_size_e'(size))
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo[1:0];
            default: bad = (|lo) | ~bus64;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_fifo.sv
// Synchronous show-ahead FIFO with a clear input; head entry is visible
// combinationally on pop_data so the issue logic can drive the bus from it.
module lsu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_pop   = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ex_lsu_issue.sv
// Load/store issue unit between EX and MEM: alignment check, request queue,
// in-order tag tracking and flush draining. Optional LSU_PERF_CNT_EN adds perf counters.
module ex_lsu_issue
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 5,
    parameter int QDEPTH    = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wr,
    input  logic [1:0]          in_size,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                in_ale,
    input  logic                flush,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [DATA_W/8-1:0] data_sram_wstrb,
    output logic [ADDR_W-1:0]   data_sram_addr,
    output logic [DATA_W-1:0]   data_sram_wdata,
    input  logic                data_sram_addr_ok,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    output logic                resp_valid,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                resp_wr,
    output logic [DATA_W-1:0]   resp_rdata
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic [TAG_W-1:0]  tag;
    } q_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             wr;
    } tag_entry_t;

    q_entry_t   new_entry, head;
    tag_entry_t tag_head;
    logic       q_full, q_empty, tag_full, tag_empty;
    logic       push_op, issue, ok_live, ok_cancel;
    logic [OFF_W-1:0] off;
    logic [CNT_W-1:0] outst_cnt_reg, outst_cnt_next, cancel_cnt_reg, cancel_cnt_next;
    logic [CNT_W:0]   pending;

    assign in_ale   = lsu_misaligned(in_size, in_addr[2:0], DATA_W == 64);
    assign in_ready = ~q_full & ~flush;
    assign push_op  = in_valid & in_ready & ~in_ale;
    assign off      = in_addr[OFF_W-1:0];

    // Lane replication and strobes are formed at enqueue so the head drives the bus directly.
    always_comb begin
        new_entry      = '0;
        new_entry.wr   = in_wr;
        new_entry.size = in_size;
        new_entry.addr = in_addr;
        new_entry.tag  = in_tag;
        case (lsu_size_e'(in_size))
            SZ_B: begin
                new_entry.wdata = {(DATA_W/8){in_wdata[7:0]}};
                new_entry.wstrb = STRB_W'(1) << off;
            end
            SZ_H: begin
                new_entry.wdata = {(DATA_W/16){in_wdata[15:0]}};
                new_entry.wstrb = STRB_W'(2'b11) << (off & ~OFF_W'(1));
            end
            SZ_W: begin
                new_entry.wdata = {(DATA_W/32){in_wdata[31:0]}};
                new_entry.wstrb = STRB_W'(4'hF) << (off & ~OFF_W'(3));
            end
            default: begin
                new_entry.wdata = in_wdata;
                new_entry.wstrb = '1;
            end
        endcase
    end

    lsu_fifo #(.WIDTH($bits(q_entry_t)), .DEPTH(QDEPTH)) u_issue_q (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .push      (push_op),
        .push_data (new_entry),
        .pop       (issue),
        .pop_data  (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Cancelled ops still occupy bus slots until their data_ok arrives.
    assign pending       = {1'b0, outst_cnt_reg} + {1'b0, cancel_cnt_reg};
    assign data_sram_req = ~q_empty & ~flush & (pending < (CNT_W+1)'(MAX_OUTST));
    assign issue         = data_sram_req & data_sram_addr_ok;

    assign data_sram_wr    = head.wr;
    assign data_sram_size  = head.size;
    assign data_sram_addr  = head.addr;
    assign data_sram_wdata = head.wdata;
    assign data_sram_wstrb = head.wstrb;

    assign ok_cancel = data_sram_data_ok & (cancel_cnt_reg != '0);
    assign ok_live   = data_sram_data_ok & (cancel_cnt_reg == '0);

    lsu_fifo #(.WIDTH($bits(tag_entry_t)), .DEPTH(MAX_OUTST)) u_tag_q (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .push      (issue),
        .push_data ({head.tag, head.wr}),
        .pop       (ok_live),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_comb begin
        outst_cnt_next  = outst_cnt_reg;
        cancel_cnt_next = cancel_cnt_reg;
        if (flush) begin
            outst_cnt_next  = '0;
            cancel_cnt_next = cancel_cnt_reg + outst_cnt_reg - CNT_W'(data_sram_data_ok);
        end else begin
            if (ok_cancel) cancel_cnt_next = cancel_cnt_reg - CNT_W'(1);
            outst_cnt_next = outst_cnt_reg + CNT_W'(issue) - CNT_W'(ok_live);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outst_cnt_reg  <= '0;
            cancel_cnt_reg <= '0;
            resp_valid     <= 1'b0;
            resp_tag       <= '0;
            resp_wr        <= 1'b0;
            resp_rdata     <= '0;
        end else begin
            outst_cnt_reg  <= outst_cnt_next;
            cancel_cnt_reg <= cancel_cnt_next;
            resp_valid     <= ok_live & ~flush;
            if (ok_live) begin
                resp_tag   <= tag_head.tag;
                resp_wr    <= tag_head.wr;
                resp_rdata <= data_sram_rdata;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!resetn)
        !(data_sram_data_ok && tag_empty && cancel_cnt_reg == '0) && !(issue && tag_full));

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (data_sram_req && !data_sram_addr_ok) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_lsu_issue.sv
// Bench for ex_lsu_issue (32-bit bus): directed scenarios plus random traffic against
// a queue-based reference model; perf counter checks only when LSU_PERF_CNT_EN is defined.
module tb_ex_lsu_issue;
    localparam int DW = 32, AW = 32, TW = 5, QD = 2, MO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, in_valid, in_ready, in_wr, in_ale, flush;
    logic [1:0] in_size;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic [TW-1:0] in_tag;
    logic data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0] data_sram_size;
    logic [DW/8-1:0] data_sram_wstrb;
    logic [AW-1:0] data_sram_addr;
    logic [DW-1:0] data_sram_wdata, data_sram_rdata;
    logic resp_valid, resp_wr;
    logic [TW-1:0] resp_tag;
    logic [DW-1:0] resp_rdata;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    ex_lsu_issue #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .QDEPTH(QD), .MAX_OUTST(MO)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr),
        .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
        .in_ale(in_ale), .flush(flush), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .resp_valid(resp_valid), .resp_tag(resp_tag),
        .resp_wr(resp_wr), .resp_rdata(resp_rdata)
`ifdef LSU_PERF_CNT_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [4:0] tag;
    } bus_t;
    typedef struct { logic [4:0] tag; logic wr; bit cancelled; } iss_t;

    bus_t bus_q[$];
    iss_t iss_q[$];
    bit resp_due;
    logic [4:0] rtag;
    logic rwr;
    logic [31:0] rdat;
    int exp_issue, exp_stall, resp_cnt, req_seen;
    logic [4:0] tags_seen[$];
    logic obs_req, obs_ready, obs_ale;
    logic [3:0] obs_wstrb;
    logic [31:0] obs_wdata;
    logic [1:0] obs_size;
    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic bit m_ale(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0: return 1'b0;
            2'd1: return (a % 2) != 0;
            2'd2: return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        int nb, m;
        nb = 1 << sz;
        m = ((1 << nb) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        int nb;
        logic [31:0] mask, r;
        nb = 1 << sz;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        r = '0;
        for (int i = 0; i < 4 / nb; i++) r |= (d & mask) << (8 * nb * i);
        return r;
    endfunction

    task automatic model_clear();
        bus_q.delete(); iss_q.delete();
        resp_due = 0; exp_issue = 0; exp_stall = 0;
    endtask

    // One bus cycle: drive at negedge, sample just after, then advance the reference model.
    task automatic cycle(input bit v, input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] tag, input bit aok, input bit dok,
                         input bit fl, output bit acc);
        bit exp_req, exp_ready, ale;
        bus_t b;
        iss_t e;
        @(negedge clk);
        in_valid = v; in_wr = wr; in_size = sz; in_addr = addr; in_wdata = wd; in_tag = tag;
        data_sram_addr_ok = aok; data_sram_data_ok = dok; flush = fl;
        data_sram_rdata = $urandom;
        #1;
        obs_req = data_sram_req; obs_ready = in_ready; obs_ale = in_ale;
        obs_wstrb = data_sram_wstrb; obs_wdata = data_sram_wdata; obs_size = data_sram_size;
        exp_ready = (bus_q.size() < QD) && !fl;
        exp_req = (bus_q.size() > 0) && !fl && (iss_q.size() < MO);
        ale = m_ale(sz, addr);
        check("in_ready", in_ready, exp_ready);
        check("in_ale", in_ale, ale);
        check("req", data_sram_req, exp_req);
        if (data_sram_req) req_seen++;
        if (exp_req) begin
            b = bus_q[0];
            check("bus_wr", data_sram_wr, b.wr);
            check("bus_size", data_sram_size, b.size);
            check("bus_addr", data_sram_addr, b.addr);
            check("bus_wstrb", data_sram_wstrb, b.wstrb);
            check("bus_wdata", data_sram_wdata, b.wdata);
        end
        check("resp_valid", resp_valid, resp_due);
        if (resp_valid) begin
            resp_cnt++;
            tags_seen.push_back(resp_tag);
        end
        if (resp_due) begin
            check("resp_tag", resp_tag, rtag);
            check("resp_wr", resp_wr, rwr);
            check("resp_rdata", resp_rdata, rdat);
        end
        resp_due = 0;
        if (dok && iss_q.size() > 0) begin
            e = iss_q.pop_front();
            if (!e.cancelled && !fl) begin
                resp_due = 1; rtag = e.tag; rwr = e.wr; rdat = data_sram_rdata;
            end
        end
        if (exp_req) begin
            if (aok) begin
                b = bus_q.pop_front();
                iss_q.push_back('{tag: b.tag, wr: b.wr, cancelled: 1'b0});
                exp_issue++;
            end else exp_stall++;
        end
        acc = v && exp_ready;
        if (acc && !ale)
            bus_q.push_back('{wr: wr, size: sz, addr: addr, wdata: m_wdata(sz, wd),
                              wstrb: m_strb(sz, addr), tag: tag});
        if (fl) begin
            bus_q.delete();
            for (int i = 0; i < iss_q.size(); i++) iss_q[i].cancelled = 1'b1;
        end
    endtask

    task automatic idle(input bit aok, input bit dok);
        bit acc;
        cycle(0, 0, 2'd0, 32'h0, 32'h0, 5'd0, aok, dok && iss_q.size() > 0, 0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while ((bus_q.size() > 0 || iss_q.size() > 0 || resp_due) && n < 60) begin
            idle(1, 1);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0; in_valid = 0; in_wr = 0; in_size = 0; in_addr = 0; in_wdata = 0; in_tag = 0;
        flush = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
        #1;
        check("reset_req", data_sram_req, 1'b0);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
`ifdef LSU_PERF_CNT_EN
        check("reset_perf_issue", perf_issue_cnt, 32'd0);
        check("reset_perf_stall", perf_stall_cnt, 32'd0);
`endif
        model_clear();
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic check_tags(input string name, input logic [4:0] exp[$]);
        check({name, "_resp_count"}, tags_seen.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check({name, "_resp_tag"}, (i < tags_seen.size()) ? tags_seen[i] : 5'bx, exp[i]);
    endtask

    initial begin
        bit acc;
        int n;
        resetn = 0;
        resp_cnt = 0; req_seen = 0;
        do_reset();

        // 1: byte store replicated across lanes
        cycle(1, 1, 2'd0, 32'h1003, 32'hAB, 5'd1, 0, 0, 0, acc);
        idle(1, 0);
        check("t1_req", obs_req, 1'b1);
        check("t1_wstrb", obs_wstrb, 4'b1000);
        check("t1_wdata", obs_wdata, 32'hABAB_ABAB);
        check("t1_size", obs_size, 2'd0);
        drain();
        $display("t1 st.b 0x1003 issued, responses=%0d", resp_cnt);

        // 2: misaligned word load is consumed and dropped
        n = resp_cnt;
        cycle(1, 0, 2'd2, 32'h2002, 32'h0, 5'd2, 1, 0, 0, acc);
        check("t2_ale", obs_ale, 1'b1);
        check("t2_ready", obs_ready, 1'b1);
        req_seen = 0;
        repeat (4) idle(1, 0);
        check("t2_no_req", req_seen, 0);
        check("t2_no_resp", resp_cnt, n);
        $display("t2 ld.w 0x2002 ale, req_seen=%0d", req_seen);

        // 3: queue fills while addr_ok is low, then drains in order
        tags_seen.delete();
        cycle(1, 1, 2'd2, 32'h100, 32'h1234_5678, 5'd11, 0, 0, 0, acc);
        cycle(1, 0, 2'd1, 32'h202, 32'h0, 5'd12, 0, 0, 0, acc);
        cycle(1, 1, 2'd0, 32'h301, 32'h5A, 5'd13, 0, 0, 0, acc);
        check("t3_full_ready", obs_ready, 1'b0);
        n = 0;
        acc = 0;
        while (!acc && n < 10) begin
            cycle(1, 1, 2'd0, 32'h301, 32'h5A, 5'd13, 1, iss_q.size() > 0, 0, acc);
            n++;
        end
        check("t3_accepted", acc, 1'b1);
        drain();
        check_tags("t3", '{5'd11, 5'd12, 5'd13});
        $display("t3 three ops, responses seen=%0d", tags_seen.size());

        // 4: flush cancels two issued loads; a later load still responds
        tags_seen.delete();
        cycle(1, 0, 2'd2, 32'h400, 32'h0, 5'd1, 1, 0, 0, acc);
        cycle(1, 0, 2'd2, 32'h404, 32'h0, 5'd2, 1, 0, 0, acc);
        idle(1, 0);
        cycle(0, 0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 1, acc);
        cycle(1, 0, 2'd2, 32'h408, 32'h0, 5'd7, 1, 0, 0, acc);
        drain();
        check_tags("t4", '{5'd7});
        $display("t4 flush with 2 outstanding, responses seen=%0d", tags_seen.size());

        // 5: data_ok in the flush cycle leaves exactly one cancelled op
        tags_seen.delete();
        cycle(1, 0, 2'd2, 32'h500, 32'h0, 5'd3, 1, 0, 0, acc);
        cycle(1, 0, 2'd2, 32'h504, 32'h0, 5'd4, 1, 0, 0, acc);
        idle(1, 0);
        cycle(0, 0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 1, 1, acc);
        cycle(1, 0, 2'd0, 32'h508, 32'h0, 5'd9, 1, 0, 0, acc);
        idle(1, 0);
        check("t5_issue_with_cancel", obs_req, 1'b1);
        drain();
        check_tags("t5", '{5'd9});
        $display("t5 flush+data_ok, responses seen=%0d", tags_seen.size());

        // Reset in the middle of traffic
        cycle(1, 1, 2'd1, 32'h600, 32'hBEEF, 5'd5, 1, 0, 0, acc);
        cycle(1, 0, 2'd2, 32'h604, 32'h0, 5'd6, 0, 0, 0, acc);
        do_reset();
        idle(0, 0);
        $display("reset mid-traffic, req after reset=%0d", obs_req);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, 5'(i), $urandom_range(0, 1),
                  iss_q.size() > 0 && $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0, acc);
        end
        drain();
        $display("random phase done, total responses=%0d", resp_cnt);

`ifdef LSU_PERF_CNT_EN
        check("perf_issue_model", perf_issue_cnt, exp_issue);
        check("perf_stall_model", perf_stall_cnt, exp_stall);
        // 6: four issues with three stall cycles
        do_reset();
        cycle(1, 0, 2'd2, 32'h700, 32'h0, 5'd1, 0, 0, 0, acc);
        cycle(1, 0, 2'd2, 32'h704, 32'h0, 5'd2, 0, 0, 0, acc);
        idle(1, 0);
        idle(0, 0);
        idle(1, 1);
        cycle(1, 0, 2'd2, 32'h708, 32'h0, 5'd3, 0, 0, 0, acc);
        cycle(1, 0, 2'd2, 32'h70C, 32'h0, 5'd4, 0, 0, 0, acc);
        idle(1, 1);
        idle(1, 1);
        drain();
        check("t6_perf_issue", perf_issue_cnt, 32'd4);
        check("t6_perf_stall", perf_stall_cnt, 32'd3);
        $display("t6 perf issue=%0d stall=%0d", perf_issue_cnt, perf_stall_cnt);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
